// File: rtl/puf_resp_engine.sv
// ---------------------------------------------------------------------------
// puf_resp_engine
//
// Ring-oscillator PUF response engine. For each of N_BITS oscillator pairs
// the engine counts rising edges of ro_a and ro_b over a fixed window. A bit
// votes 1 for a round when the A oscillator is faster. After VOTES rounds
// the majority decides the response bit. A bit is flagged unstable when its
// rounds did not all agree.
//
// Parameters
//   N_BITS     number of response bits / oscillator pairs
//   CHAL_W     challenge width
//   CNT_W      edge-counter width (counters saturate)
//   WINDOW     COUNT cycles per round
//   VOTES      measurement rounds per response (odd, 1..15)
//   SETTLE_CYC SETTLE cycles per round (>= 3, covers the synchroniser depth)
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   start      measurement request, only looked at in IDLE
//   challenge  challenge, captured into ro_sel when start is accepted
//   ro_a/ro_b  oscillator outputs, asynchronous to clk
//   ro_en      oscillator bank enable (SETTLE and COUNT only)
//   ro_sel     captured challenge driven to the oscillator bank
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle completion pulse
//   response   majority-voted response, held until the next completion
//   unstable   per-bit flag, set when the rounds disagreed
// ---------------------------------------------------------------------------
module puf_resp_engine #(
  parameter int N_BITS     = 8,
  parameter int CHAL_W     = 8,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int VOTES      = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  input  logic [N_BITS-1:0] ro_a,
  input  logic [N_BITS-1:0] ro_b,
  output logic              ro_en,
  output logic [CHAL_W-1:0] ro_sel,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] response,
  output logic [N_BITS-1:0] unstable
);

  // The phase counter is shared by SETTLE and COUNT, so it is sized for
  // whichever of the two is longer.
  localparam int CYC_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] COUNT_LAST  = CYC_W'(WINDOW - 1);
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       VOTE_ALL    = 4'(VOTES);
  localparam logic [3:0]       VOTE_HALF   = 4'(VOTES / 2);
  localparam logic [3:0]       LAST_ROUND  = 4'(VOTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [3:0]        round_idx;
  logic [3:0]        votes      [N_BITS];
  logic [3:0]        votes_next [N_BITS];
  logic [CNT_W-1:0]  cnt_a      [N_BITS];
  logic [CNT_W-1:0]  cnt_b      [N_BITS];
  logic [N_BITS-1:0] a_s1, a_s2, a_s3;
  logic [N_BITS-1:0] b_s1, b_s2, b_s3;
  logic [N_BITS-1:0] edge_a, edge_b;
  logic [N_BITS-1:0] round_res;
  logic [N_BITS-1:0] resp_next;
  logic [N_BITS-1:0] unst_next;

  // Two flops bring the oscillators into the clk domain; the third flop
  // only remembers the previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1 <= '0;
      a_s2 <= '0;
      a_s3 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
      b_s3 <= '0;
    end else begin
      a_s1 <= ro_a;
      a_s2 <= a_s1;
      a_s3 <= a_s2;
      b_s1 <= ro_b;
      b_s2 <= b_s1;
      b_s3 <= b_s2;
    end
  end

  assign edge_a = a_s2 & ~a_s3;
  assign edge_b = b_s2 & ~b_s3;

  // Edge counters. They are cleared throughout SETTLE so edges caused by
  // the oscillators starting up never reach a count, and they only advance
  // during COUNT. Saturation keeps a very fast oscillator from wrapping to a
  // small value and losing the comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BITS; i++) begin
        cnt_a[i] <= '0;
        cnt_b[i] <= '0;
      end
    end else if (state == S_SETTLE) begin
      for (int i = 0; i < N_BITS; i++) begin
        cnt_a[i] <= '0;
        cnt_b[i] <= '0;
      end
    end else if (state == S_COUNT) begin
      for (int i = 0; i < N_BITS; i++) begin
        if (edge_a[i] && (cnt_a[i] != CNT_SAT)) begin
          cnt_a[i] <= cnt_a[i] + CNT_ONE;
        end
        if (edge_b[i] && (cnt_b[i] != CNT_SAT)) begin
          cnt_b[i] <= cnt_b[i] + CNT_ONE;
        end
      end
    end
  end

  // Result of the round being compared, and what the response would be if
  // this were the last round. A tie counts as a 0 vote.
  always_comb begin
    round_res = '0;
    resp_next = '0;
    unst_next = '0;
    for (int i = 0; i < N_BITS; i++) begin
      round_res[i]  = (cnt_a[i] > cnt_b[i]);
      votes_next[i] = votes[i] + {3'b000, round_res[i]};
      resp_next[i]  = (votes_next[i] > VOTE_HALF);
      unst_next[i]  = (votes_next[i] != 4'd0) && (votes_next[i] != VOTE_ALL);
    end
  end

  // Main sequencer. All outputs are registered and change together with the
  // state, so ro_en, busy and done line up exactly with the state they
  // describe. The response registers are written only on the way into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cyc       <= '0;
      round_idx <= '0;
      ro_sel    <= '0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= '0;
      unstable  <= '0;
      for (int i = 0; i < N_BITS; i++) begin
        votes[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_SETTLE;
            ro_sel    <= challenge;
            cyc       <= '0;
            round_idx <= '0;
            ro_en     <= 1'b1;
            busy      <= 1'b1;
            for (int i = 0; i < N_BITS; i++) begin
              votes[i] <= '0;
            end
          end
        end

        S_SETTLE: begin
          if (cyc == SETTLE_LAST) begin
            cyc   <= '0;
            state <= S_COUNT;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end

        S_COUNT: begin
          if (cyc == COUNT_LAST) begin
            cyc   <= '0;
            ro_en <= 1'b0;
            state <= S_COMPARE;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end

        S_COMPARE: begin
          votes     <= votes_next;
          round_idx <= round_idx + 4'd1;
          if (round_idx == LAST_ROUND) begin
            state    <= S_DONE;
            done     <= 1'b1;
            response <= resp_next;
            unstable <= unst_next;
          end else begin
            state <= S_SETTLE;
            ro_en <= 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          ro_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_engine.sv
// ---------------------------------------------------------------------------
// tb_puf_resp_engine
//
// Directed bench for puf_resp_engine. The main instance uses WINDOW=16,
// VOTES=3, SETTLE_CYC=4; a second instance with CNT_W=4, WINDOW=40 shows
// counter saturation. Oscillators are modelled as a fast wave (rising edge
// every 2 clk cycles) and a slow wave (rising edge every 8 clk cycles),
// selected per bit by masks. Per round the fast wave gives 8 edges in a
// 16-cycle window and the slow wave 2; in the 40-cycle window 20 and 5.
//
// Latency is counted as the number of clk edges after the accepting edge
// up to the edge at which done is first sampled high:
//   main instance   1 + 3*(4+16+1) = 64
//   second instance 1 + 3*(4+40+1) = 136
// ---------------------------------------------------------------------------
module tb_puf_resp_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start2;
  logic [7:0] challenge;
  logic [7:0] ro_a;
  logic [7:0] ro_b;

  logic       ro_en,  busy,  done;
  logic [7:0] ro_sel, response,  unstable;
  logic       ro_en2, busy2, done2;
  logic [7:0] ro_sel2, response2, unstable2;

  int tests_run    = 0;
  int tests_failed = 0;

  // Oscillator model state
  bit       fast_wave;
  bit       slow_wave;
  bit       en_prev;
  int       tick;
  int       rnd;
  int       rnd_base;
  bit       flip_m;
  bit [7:0] a_fast_m, a_slow_m, b_fast_m, b_slow_m;

  puf_resp_engine #(
    .N_BITS(8), .CHAL_W(8), .CNT_W(16), .WINDOW(16), .VOTES(3), .SETTLE_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .ro_sel(ro_sel),
    .busy(busy), .done(done), .response(response), .unstable(unstable)
  );

  puf_resp_engine #(
    .N_BITS(8), .CHAL_W(8), .CNT_W(4), .WINDOW(40), .VOTES(3), .SETTLE_CYC(4)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en2), .ro_sel(ro_sel2),
    .busy(busy2), .done(done2), .response(response2), .unstable(unstable2)
  );

  always #5 clk = ~clk;

  // Oscillator generator. The round number follows falling edges of ro_en
  // so bit 3 can be made to lose only the middle round when flip_m is set.
  always @(negedge clk) begin
    logic [7:0] a_now;
    logic [7:0] b_now;
    logic       tmp;
    tick      = tick + 1;
    fast_wave = ~fast_wave;
    if ((tick % 4) == 0) slow_wave = ~slow_wave;
    if (en_prev && !ro_en) rnd = rnd + 1;
    en_prev = ro_en;
    a_now = (a_fast_m & {8{fast_wave}}) | (a_slow_m & {8{slow_wave}});
    b_now = (b_fast_m & {8{fast_wave}}) | (b_slow_m & {8{slow_wave}});
    if (flip_m && ((rnd - rnd_base) == 1)) begin
      tmp      = a_now[3];
      a_now[3] = b_now[3];
      b_now[3] = tmp;
    end
    ro_a = a_now;
    ro_b = b_now;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Sets the oscillator patterns and challenge, then pulses start (or start2)
  // across one rising edge. Called just after a negedge; returns at edge+1.
  task automatic applyStimulus(input bit [7:0] af, input bit [7:0] as,
                               input bit [7:0] bf, input bit [7:0] bs,
                               input bit flip, input logic [7:0] chal,
                               input bit use2);
    a_fast_m  = af;
    a_slow_m  = as;
    b_fast_m  = bf;
    b_slow_m  = bs;
    flip_m    = flip;
    rnd_base  = rnd;
    challenge = chal;
    if (use2) start2 = 1'b1;
    else      start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Waits, one negedge at a time, for the first done of the chosen instance.
  // lat is -1 when the budget expires.
  task automatic waitDone(input int limit, input bit use2, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if ((use2 ? done2 : done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;

    reset     = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    challenge = 8'h00;
    a_fast_m  = '0;
    a_slow_m  = '0;
    b_fast_m  = '0;
    b_slow_m  = '0;
    flip_m    = 1'b0;
    rnd_base  = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",     busy,     0);
    checkOutput("reset_done",     done,     0);
    checkOutput("reset_ro_en",    ro_en,    0);
    checkOutput("reset_response", response, 0);
    checkOutput("reset_unstable", unstable, 0);
    checkOutput("reset_ro_sel",   ro_sel,   0);

    // A faster on every bit; start on the first edge after reset release
    reset = 1'b0;
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    checkOutput("t1_ro_en_running", ro_en, 1);
    waitDone(200, 1'b0, lat);
    checkOutput("t1_latency",  lat,      64);
    checkOutput("t1_ro_sel",   ro_sel,   8'hA5);
    checkOutput("t1_response", response, 8'hFF);
    checkOutput("t1_unstable", unstable, 8'h00);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", done, 0);
    checkOutput("t1_busy_idle",      busy, 0);
    checkOutput("t1_response_hold",  response, 8'hFF);

    // B faster on every bit
    applyStimulus(8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b0);
    waitDone(200, 1'b0, lat);
    checkOutput("t2_latency",  lat,      64);
    checkOutput("t2_response", response, 8'h00);
    checkOutput("t2_unstable", unstable, 8'h00);
    @(negedge clk);

    // Identical streams tie every round
    applyStimulus(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b0);
    waitDone(200, 1'b0, lat);
    checkOutput("t3_response", response, 8'h00);
    checkOutput("t3_unstable", unstable, 8'h00);
    @(negedge clk);

    // Bit 3 loses only the middle round: votes 2 of 3
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1, 8'hA5, 1'b0);
    waitDone(200, 1'b0, lat);
    checkOutput("t4_latency",  lat,      64);
    checkOutput("t4_response", response, 8'hFF);
    checkOutput("t4_unstable", unstable, 8'h08);
    @(negedge clk);

    // Reset during the second round's COUNT window aborts the run
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("t5_busy_before", busy,  1);
    checkOutput("t5_en_before",   ro_en, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_ro_en_async", ro_en,    0);
    checkOutput("t5_busy_async",  busy,     0);
    checkOutput("t5_response",    response, 8'h00);
    checkOutput("t5_ro_sel",      ro_sel,   8'h00);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checkOutput("t5_no_done",       ndone,    0);
    checkOutput("t5_response_hold", response, 8'h00);
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    waitDone(200, 1'b0, lat);
    checkOutput("t5_restart_latency",  lat,      64);
    checkOutput("t5_restart_response", response, 8'hFF);
    @(negedge clk);

    // Second start with a new challenge while busy is ignored
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    repeat (5) @(negedge clk);
    challenge = 8'h3C;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6_ro_sel_busy", ro_sel, 8'hA5);
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checkOutput("t6_single_done", ndone,  1);
    checkOutput("t6_ro_sel_end",  ro_sel, 8'hA5);
    checkOutput("t6_busy_end",    busy,   0);

    // start held high: IDLE for one cycle, busy again 2 edges after done
    challenge = 8'hA5;
    start     = 1'b1;
    @(posedge clk);
    waitDone(200, 1'b0, lat);
    checkOutput("t7_latency", lat, 64);
    @(negedge clk);
    checkOutput("t7_idle_gap", busy, 0);
    @(negedge clk);
    checkOutput("t7_rebusy", busy, 1);
    start = 1'b0;
    // Second run was accepted one edge before this point, so 63 remain
    waitDone(200, 1'b0, lat);
    checkOutput("t7_second_latency", lat, 63);
    @(negedge clk);

    // Narrow counters: fast A gives 20 edges, saturates at 15, beats B's 5
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h5A, 1'b1);
    waitDone(400, 1'b1, lat);
    checkOutput("t8_latency",  lat,       136);
    checkOutput("t8_response", response2, 8'hFF);
    checkOutput("t8_unstable", unstable2, 8'h00);
    checkOutput("t8_ro_sel",   ro_sel2,   8'h5A);
    @(negedge clk);
    checkOutput("t8_idle", {busy2, ro_en2, done2}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
